// File: rtl/sid_i2s_tx_pkg.sv
// sid: shared types and constants for the SID audio output path.
// Holds the stereo sample type, the I2S pin bundle and the slot-bit selector
// used by sid_i2s_tx to serialise a 48-bit frame buffer.
package sid;

   localparam int unsigned I2S_FRAME_BITS = 64;
   localparam int unsigned SAMPLE_BITS    = 24;

   typedef struct packed {
      logic signed [SAMPLE_BITS-1:0] left;
      logic signed [SAMPLE_BITS-1:0] right;
   } audio_t;

   typedef struct packed {
      logic bck;
      logic lrck;
      logic sd;
   } i2s_o_t;

   // Serial bit for frame position bit_idx. Left occupies frame[47:24] and
   // right frame[23:0]; slot position p carries channel bit 24-p, so the MSB
   // goes out one BCK after the LRCK change and p=0, 25..31 are padding.
   function automatic logic slot_bit(input logic [47:0] frame, input logic [5:0] bit_idx);
      logic [4:0] p;
      logic [5:0] idx;
      logic       res;
      p   = bit_idx[4:0];
      idx = '0;
      res = 1'b0;
      if (p >= 5'd1 && p <= 5'd24) begin
         idx = bit_idx[5] ? (6'd24 - 6'(p)) : (6'd48 - 6'(p));
         res = frame[idx];
      end
      return res;
   endfunction

endpackage

// File: rtl/sid_i2s_tx_clkgen.sv
// sid_i2s_clkgen: BCK divider and 64-bit I2S frame counter.
// Produces the registered BCK, a strobe for the clk edge on which BCK falls,
// the bit counter value that takes effect on that edge, and the frame start.
module sid_i2s_clkgen
   import sid::*;
#(
   parameter int unsigned BCK_HALF = 4
) (
   input  logic       clk,
   input  logic       rst,
   output logic       bck_o,
   output logic       fall_o,
   output logic       frame_start_o,
   output logic [5:0] bit_next_o
);

   localparam logic [7:0] DivLast = 8'(BCK_HALF - 1);
   localparam logic [5:0] BitLast = 6'(I2S_FRAME_BITS - 1);

   logic [7:0] div_cnt_q, div_cnt_d;
   logic       bck_q, bck_d;
   logic [5:0] bit_cnt_q, bit_cnt_d;
   logic       wrap;

   // Divider wrap toggles BCK; a wrap while BCK is high is the falling edge,
   // which advances the bit counter. The 63->0 advance is the frame start.
   always_comb begin
      wrap          = (div_cnt_q == DivLast);
      div_cnt_d     = wrap ? 8'd0 : div_cnt_q + 8'd1;
      bck_d         = wrap ? ~bck_q : bck_q;
      fall_o        = wrap & bck_q;
      bit_next_o    = bit_cnt_q + 6'd1;
      bit_cnt_d     = fall_o ? bit_next_o : bit_cnt_q;
      frame_start_o = fall_o & (bit_cnt_q == BitLast);
   end

   // Divider and frame counter state; bit_cnt parks at 63 so the first
   // falling edge after reset starts a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         bck_q     <= 1'b0;
         bit_cnt_q <= BitLast;
      end else begin
         div_cnt_q <= div_cnt_d;
         bck_q     <= bck_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bck_o = bck_q;

endmodule

// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx: stereo 24-bit I2S transmitter with a one-sample holding register.
// A sample accepted on valid && ready waits in the holding register until the
// next frame start, then moves to the 48-bit frame buffer that feeds sd.
// Frames that start with the holding register empty replay the last sample
// and pulse underrun.
// Optional build macro SID_I2S_STALE_MUTE_EN: after STALE_FRAMES consecutive
// underrun frames the replay source becomes silence until a new sample lands.
module sid_i2s_tx
   import sid::*;
#(
   parameter int unsigned BCK_HALF     = 4,
   parameter int unsigned STALE_FRAMES = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  audio_t audio_i,
   input  logic   valid,
   output logic   ready,
   output i2s_o_t i2s_o,
   output logic   underrun
);

   if (BCK_HALF < 1 || BCK_HALF > 255) begin : g_bad_bck_half
      $error("sid_i2s_tx: BCK_HALF must be 1..255");
   end
   if (STALE_FRAMES < 1 || STALE_FRAMES > 255) begin : g_bad_stale_frames
      $error("sid_i2s_tx: STALE_FRAMES must be 1..255");
   end

   logic       bck;
   logic       fall;
   logic       frame_start;
   logic [5:0] bit_next;

   sid_i2s_clkgen #(
      .BCK_HALF(BCK_HALF)
   ) u_clkgen (
      .clk          (clk),
      .rst          (rst),
      .bck_o        (bck),
      .fall_o       (fall),
      .frame_start_o(frame_start),
      .bit_next_o   (bit_next)
   );

   audio_t      hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [47:0] frame_q, frame_d;
   audio_t      last_q, last_d;
   logic        lrck_q, lrck_d;
   logic        sd_q, sd_d;
   logic        underrun_q, underrun_d;
   audio_t      replay;
   logic        accept;

`ifdef SID_I2S_STALE_MUTE_EN
   localparam logic [7:0] StaleMax = 8'(STALE_FRAMES);

   logic [7:0] stale_cnt_q, stale_cnt_d;

   // Count consecutive underrun frames, saturating; a delivered sample clears.
   always_comb begin
      stale_cnt_d = stale_cnt_q;
      if (frame_start) begin
         if (hold_full_q) begin
            stale_cnt_d = '0;
         end else if (stale_cnt_q < StaleMax) begin
            stale_cnt_d = stale_cnt_q + 8'd1;
         end
      end
   end

   // Stale counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         stale_cnt_q <= '0;
      end else begin
         stale_cnt_q <= stale_cnt_d;
      end
   end

   // Replay silence once the source has been absent for too long.
   assign replay = (stale_cnt_q >= StaleMax) ? '0 : last_q;
`else
   assign replay = last_q;
`endif

   // ready is low exactly while the holding register is occupied, so an
   // accepted sample can never be overwritten.
   assign ready  = ~hold_full_q;
   assign accept = valid & ~hold_full_q;

   // Next-state for the sample path and the serial outputs. Transfer and
   // accept are exclusive: transfer needs a full holding register, accept an
   // empty one, so a same-clk accept at an empty frame start waits a frame.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      frame_d     = frame_q;
      last_d      = last_q;
      lrck_d      = lrck_q;
      sd_d        = sd_q;
      underrun_d  = 1'b0;

      if (frame_start) begin
         if (hold_full_q) begin
            frame_d     = hold_q;
            last_d      = hold_q;
            hold_full_d = 1'b0;
         end else begin
            frame_d    = replay;
            underrun_d = 1'b1;
         end
      end

      if (accept) begin
         hold_d      = audio_i;
         hold_full_d = 1'b1;
      end

      // p=0 is padding, so the buffer being reloaded on this edge is harmless.
      if (fall) begin
         lrck_d = bit_next[5];
         sd_d   = slot_bit(frame_q, bit_next);
      end
   end

   // Sample path and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         frame_q     <= '0;
         last_q      <= '0;
         lrck_q      <= 1'b0;
         sd_q        <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         frame_q     <= frame_d;
         last_q      <= last_d;
         lrck_q      <= lrck_d;
         sd_q        <= sd_d;
         underrun_q  <= underrun_d;
      end
   end

   assign i2s_o    = '{bck: bck, lrck: lrck_q, sd: sd_q};
   assign underrun = underrun_q;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb_sid_i2s_tx: directed stimulus for sid_i2s_tx with a frame scoreboard.
// The driver pushes the expected content of every frame; the monitor
// deserialises sd/lrck on BCK rising edges and pops one entry per frame.
module tb_sid_i2s_tx;
   import sid::*;

   localparam int unsigned BckHalf  = 2;
   localparam int unsigned FrameClk = 64 * 2 * BckHalf;

   logic   clk = 1'b0;
   logic   rst;
   audio_t audio_i;
   logic   valid;
   logic   ready;
   i2s_o_t i2s_o;
   logic   underrun;

   always #5 clk = ~clk;

   sid_i2s_tx #(
      .BCK_HALF    (BckHalf),
      .STALE_FRAMES(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .audio_i (audio_i),
      .valid   (valid),
      .ready   (ready),
      .i2s_o   (i2s_o),
      .underrun(underrun)
   );

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic        ur;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   frames_started = 0;
   int   fs_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
      end
   endtask

   task automatic push(input logic [23:0] l, input logic [23:0] r, input logic ur);
      exp_t e;
      e.l = l;
      e.r = r;
      e.ur = ur;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic        prev_bck = 1'b0;
   logic        prev_lrck = 1'b0;
   logic        prev_sd = 1'b0;
   logic        first_pending = 1'b1;
   logic        capturing = 1'b0;
   logic        have_prev_fs = 1'b0;
   int          pos = 0;
   int          p = 0;
   int          last_rise = 0;
   int          prev_fs = 0;
   logic [23:0] got_l, got_r;
   logic        ur_seen = 1'b0;
   logic        fmt_ok = 1'b1;
   exp_t        e_mon;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            capturing     = 1'b0;
            first_pending = 1'b1;
            have_prev_fs  = 1'b0;
         end else begin
            if (underrun) ur_seen = 1'b1;
            if (prev_bck && !i2s_o.bck && (first_pending || (prev_lrck && !i2s_o.lrck))) begin
               if (capturing) begin
                  total++;
                  bad++;
                  $display("FAIL frame_short: got %0d bits want 64", pos);
               end
               if (have_prev_fs) check("frame_period", 64'(cyc - prev_fs), 64'(FrameClk));
               prev_fs       = cyc;
               have_prev_fs  = 1'b1;
               fs_cyc        = cyc;
               frames_started++;
               first_pending = 1'b0;
               capturing     = 1'b1;
               pos           = 0;
               got_l         = '0;
               got_r         = '0;
               ur_seen       = underrun;
               fmt_ok        = 1'b1;
            end else if (capturing && !prev_bck && i2s_o.bck) begin
               if (pos > 0 && (cyc - last_rise) != 2 * BckHalf) fmt_ok = 1'b0;
               last_rise = cyc;
               if (i2s_o.sd !== prev_sd) fmt_ok = 1'b0;
               if (i2s_o.lrck !== (pos >= 32)) fmt_ok = 1'b0;
               p = pos % 32;
               if (p >= 1 && p <= 24) begin
                  if (pos < 32) got_l[24-p] = i2s_o.sd;
                  else got_r[24-p] = i2s_o.sd;
               end else if (i2s_o.sd !== 1'b0) begin
                  fmt_ok = 1'b0;
               end
               pos++;
               if (pos == 64) begin
                  capturing = 1'b0;
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_frame: got l=%h r=%h want no frame", got_l, got_r);
                  end else begin
                     e_mon = exp_q.pop_front();
                     check("frame_left", 64'(got_l), 64'(e_mon.l));
                     check("frame_right", 64'(got_r), 64'(e_mon.r));
                     check("frame_underrun", 64'(ur_seen), 64'(e_mon.ur));
                     check("frame_format", 64'(fmt_ok), 64'(1));
                  end
               end
            end
         end
         prev_bck  = i2s_o.bck;
         prev_lrck = i2s_o.lrck;
         prev_sd   = i2s_o.sd;
      end
   end

   // ---------------- driver ----------------
   task automatic wait_frames(input int n);
      int budget;
      budget = 2000;
      while (frames_started < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (frames_started < n) begin
         total++;
         bad++;
         $display("FAIL wait_frames: got %0d starts want %0d", frames_started, n);
      end
   endtask

   task automatic send(input logic [23:0] l, input logic [23:0] r, input bit keep_valid);
      int budget;
      budget = 2000;
      @(negedge clk);
      audio_i = {l, r};
      valid   = 1'b1;
      while (!ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got ready=0 want 1");
      end
      @(posedge clk);
      #1;
      if (!keep_valid) valid = 1'b0;
      @(negedge clk);
      check("ready_after_accept", 64'(ready), 64'(0));
   endtask

   int base;
   int t;

   initial begin
      rst     = 1'b1;
      valid   = 1'b0;
      audio_i = '0;
      // Idle after reset: silent frames, each an underrun.
      push(24'h0, 24'h0, 1'b1);
      push(24'h0, 24'h0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Single sample, then one replayed frame.
      wait_frames(2);
      repeat (10) @(negedge clk);
      push(24'hA50F3C, 24'h800001, 1'b0);
      push(24'hA50F3C, 24'h800001, 1'b1);
      send(24'hA50F3C, 24'h800001, 1'b0);

      // valid held high: one accept per frame, no underruns.
      wait_frames(4);
      push(24'h123456, 24'hFEDCBA, 1'b0);
      push(24'h000001, 24'h7FFFFF, 1'b0);
      push(24'h800000, 24'h5A5A5A, 1'b0);
      send(24'h123456, 24'hFEDCBA, 1'b1);
      send(24'h000001, 24'h7FFFFF, 1'b1);
      send(24'h800000, 24'h5A5A5A, 1'b0);

      // Accept on the very clk of an empty frame start.
      wait_frames(7);
      push(24'h800000, 24'h5A5A5A, 1'b1);
      push(24'h0F0F0F, 24'hF0F0F0, 1'b0);
      t = fs_cyc + FrameClk - 1;
      while (cyc < t) @(negedge clk);
      audio_i = {24'h0F0F0F, 24'hF0F0F0};
      valid   = 1'b1;
      check("ready_at_frame_start", 64'(ready), 64'(1));
      @(posedge clk);
      #1;
      valid = 1'b0;

      // Reset at bit_cnt=40 with a sample held; it must never be sent.
      wait_frames(10);
      send(24'hABCDEF, 24'h654321, 1'b0);
      t = fs_cyc + 40 * 2 * BckHalf;
      while (cyc < t) @(negedge clk);
      rst = 1'b1;
      push(24'h0, 24'h0, 1'b1);
      push(24'h0, 24'h0, 1'b1);
      repeat (2) begin
         @(negedge clk);
         check("rst_i2s", 64'(i2s_o), 64'(0));
         check("rst_ready", 64'(ready), 64'(1));
         check("rst_underrun", 64'(underrun), 64'(0));
      end
      rst  = 1'b0;
      base = frames_started;

      // One full-scale sample then starvation; then fresh data.
      wait_frames(base + 2);
      push(24'h7FFFFF, 24'h7FFFFF, 1'b0);
      push(24'h7FFFFF, 24'h7FFFFF, 1'b1);
      push(24'h7FFFFF, 24'h7FFFFF, 1'b1);
`ifdef SID_I2S_STALE_MUTE_EN
      push(24'h000000, 24'h000000, 1'b1);
`else
      push(24'h7FFFFF, 24'h7FFFFF, 1'b1);
`endif
      push(24'h135790, 24'h2468AC, 1'b0);
      send(24'h7FFFFF, 24'h7FFFFF, 1'b0);
      wait_frames(base + 6);
      send(24'h135790, 24'h2468AC, 1'b0);

      t = 3000;
      while (exp_q.size() > 0 && t > 0) begin
         @(negedge clk);
         t--;
      end
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before 500000");
      $fatal(1, "watchdog");
   end

endmodule
